// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, fetch FSM encoding and fetch-entry payload for the fetch stage.
package instruction_fetch_unit_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC, wraps modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

    // Force a branch target onto a word boundary
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and decode-facing outputs.
// FETCH_COUNT / STALL_COUNT exist only when IFU_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic               IMEM_REQ;
    logic [ADDR_W-1:0]  IMEM_ADDR;
    logic               IMEM_ACK;
    logic [INSTR_W-1:0] IMEM_RDATA;
    logic               REDIRECT;
    logic [ADDR_W-1:0]  REDIRECT_PC;
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic [INSTR_W-1:0] INSTRUCTION;
    logic [ADDR_W-1:0]  INSTR_PC;
    logic [ADDR_W-1:0]  NEXT_PC;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]        FETCH_COUNT;
    logic [31:0]        STALL_COUNT;
`endif

    modport master (
        output IMEM_REQ, IMEM_ADDR,
        input  IMEM_ACK, IMEM_RDATA,
        input  REDIRECT, REDIRECT_PC,
        output INSTR_VALID,
        input  INSTR_READY,
        output INSTRUCTION, INSTR_PC, NEXT_PC
`ifdef IFU_PERF_CNT_EN
        , output FETCH_COUNT, STALL_COUNT
`endif
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR,
        output IMEM_ACK, IMEM_RDATA,
        output REDIRECT, REDIRECT_PC,
        input  INSTR_VALID,
        output INSTR_READY,
        input  INSTRUCTION, INSTR_PC, NEXT_PC
`ifdef IFU_PERF_CNT_EN
        , input FETCH_COUNT, STALL_COUNT
`endif
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO of fetch entries with flush; push on full is accepted only alongside a pop.
module instruction_fetch_unit_fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointer / occupancy update; flush wins over push and pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status views of the registered state
    always_comb begin
        head  = mem_q[rd_ptr_q];
        full  = (cnt_q == CNT_W'(DEPTH));
        empty = (cnt_q == '0);
        count = cnt_q;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one outstanding instruction-memory read at a time,
// buffers returned words with their PC and handles branch redirects (including a redirect
// that lands while a read is still pending, which is drained and discarded).
// Optional build macro IFU_PERF_CNT_EN adds FETCH_COUNT and STALL_COUNT.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(0),
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    instruction_fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic              imem_req, ack, push, pop, flush, room;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [CNT_W-1:0]  buf_count, count_after;
    logic              buf_full, buf_empty;
    fetch_entry_t      push_data, head;

    instruction_fetch_unit_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (CLOCK),
        .rst       (RESET),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Handshake qualification and post-edge occupancy; redirect beats pop and push
    always_comb begin
        imem_req     = (state_q != IDLE);
        ack          = bus.IMEM_ACK && imem_req;
        flush        = bus.REDIRECT;
        redirect_tgt = word_align(bus.REDIRECT_PC);
        pop          = bus.INSTR_READY && !buf_empty && !bus.REDIRECT;
        push         = ack && (state_q == REQ) && !bus.REDIRECT && (!buf_full || pop);
        push_data    = '{pc: addr_q, instr: bus.IMEM_RDATA};
        count_after  = flush ? '0 : (buf_count + CNT_W'(push) - CNT_W'(pop));
        room         = (count_after < CNT_W'(BUF_DEPTH));
    end

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state and fetch-address selection
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REDIRECT) begin
                    addr_d  = redirect_tgt;
                    state_d = REQ;
                end else if (room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.REDIRECT) begin
                    if (ack) begin
                        addr_d  = redirect_tgt;
                        state_d = REQ;
                    end else begin
                        tgt_d   = redirect_tgt;
                        state_d = DRAIN;
                    end
                end else if (ack) begin
                    addr_d  = pc_inc(addr_q);
                    state_d = room ? REQ : IDLE;
                end
            end
            DRAIN: begin
                tgt_d = bus.REDIRECT ? redirect_tgt : tgt_q;
                if (ack) begin
                    addr_d  = tgt_d;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs; head fields read as zero while the buffer is empty
    always_comb begin
        bus.IMEM_REQ    = imem_req;
        bus.IMEM_ADDR   = addr_q;
        bus.INSTR_VALID = !buf_empty;
        bus.INSTRUCTION = buf_empty ? '0 : head.instr;
        bus.INSTR_PC    = buf_empty ? '0 : head.pc;
        bus.NEXT_PC     = buf_empty ? '0 : pc_inc(head.pc);
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Accepted reads (discarded ones included) and cycles with nothing for decode
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(ack);
        stall_cnt_d = stall_cnt_q + 32'(buf_empty);
    end

    // Performance counter registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        bus.FETCH_COUNT = fetch_cnt_q;
        bus.STALL_COUNT = stall_cnt_q;
    end
`endif

endmodule
